// File: rtl/dim1_pkg.sv
// Shared types and helpers for diminished-one arithmetic modulo 2^width + 1.
package dim1_pkg;
    localparam int DIM1_WIDTH = 8;
    localparam int DIM1_MAX_W = 64;

    typedef struct packed {
        logic                  zero;
        logic [DIM1_WIDTH-1:0] data;
    } dim1_t;

    localparam dim1_t DIM1_ZERO = '{zero: 1'b1, data: '0};

    // True when a == ~b over the low w bits, i.e. the operands' true values sum to 2^w + 1.
    function automatic logic dim1_is_neg(input logic [DIM1_MAX_W-1:0] a,
                                         input logic [DIM1_MAX_W-1:0] b,
                                         input int w);
        logic [DIM1_MAX_W-1:0] mask;
        mask = (w >= DIM1_MAX_W) ? '1 : ((DIM1_MAX_W'(1) << w) - DIM1_MAX_W'(1));
        return ((a ^ ~b) & mask) == '0;
    endfunction
endpackage

// File: rtl/add_mod_2np1.sv
// Combinational diminished-one adder modulo 2^width + 1 (inverted end-around carry).
module AddMod2Np1 #(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] s
);
    logic [width:0] t;

    generate
        if (speed == 0) begin : g_serial
            always_comb begin
                logic c;
                t = '0;
                c = 1'b0;
                for (int i = 0; i < width; i++) begin
                    t[i] = a[i] ^ b[i] ^ c;
                    c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
                end
                t[width] = c;
            end
        end else begin : g_prefix
            assign t = {1'b0, a} + {1'b0, b};
        end
    endgenerate

    // A carry out already absorbed the modulus; otherwise the diminished-one +1 is still owed.
    assign s = t[width] ? t[width-1:0] : t[width-1:0] + width'(1);
endmodule

// File: rtl/dim1_mod_accumulator_add_zero.sv
// Next-sum logic: zero-flag rules, negation detection and the modular adder.
module dim1_add_zero
    import dim1_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic [width-1:0] acc_data,
    input  logic             acc_zero,
    input  logic [width-1:0] in_data,
    input  logic             in_zero,
    output logic [width-1:0] sum_data,
    output logic             sum_zero
);
    logic [width-1:0] add_s;
    logic             neg;

    AddMod2Np1 #(.width(width), .speed(speed)) u_add (
        .a(acc_data),
        .b(in_data),
        .s(add_s)
    );

    assign neg = dim1_is_neg(DIM1_MAX_W'(acc_data), DIM1_MAX_W'(in_data), width);

    always_comb begin
        sum_zero = 1'b0;
        sum_data = add_s;
        if (in_zero) begin
            sum_zero = acc_zero;
            sum_data = acc_zero ? '0 : acc_data;
        end else if (acc_zero) begin
            sum_data = in_data;
        end else if (neg) begin
            // The adder would return representation 0 (value 1) here; the true sum is 0.
            sum_zero = 1'b1;
            sum_data = '0;
        end
    end
endmodule

// File: rtl/dim1_mod_accumulator.sv
// Framed streaming accumulator modulo 2^width + 1 with valid/ready on both sides.
// Optional DIM1_MOD_ACC_BEAT_COUNT_EN adds out_count_o (beats per reported frame).
module dim1_mod_accumulator
    import dim1_pkg::*;
#(
    parameter int width = 8,
    parameter int speed = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] in_data_i,
    input  logic             in_zero_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [width-1:0] out_data_o,
    output logic             out_zero_o
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
    ,
    output logic [15:0]      out_count_o
`endif
);
    // Handshake: a beat moves when valid & ready are both high at a rising clk_i edge.
    logic [width-1:0] acc_q;
    logic             acc_zero_q;
    logic [width-1:0] out_data_q;
    logic             out_zero_q;
    logic             out_valid_q;
    logic [width-1:0] sum_data;
    logic             sum_zero;
    logic             accept;

    dim1_add_zero #(.width(width), .speed(speed)) u_add_zero (
        .acc_data(acc_q),
        .acc_zero(acc_zero_q),
        .in_data (in_data_i),
        .in_zero (in_zero_i),
        .sum_data(sum_data),
        .sum_zero(sum_zero)
    );

    assign in_ready_o  = !out_valid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_zero_o  = out_zero_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            acc_zero_q  <= DIM1_ZERO.zero;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept && in_last_i) begin
                out_data_q  <= sum_data;
                out_zero_q  <= sum_zero;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
                acc_zero_q  <= 1'b1;
            end else begin
                if (accept) begin
                    acc_q      <= sum_data;
                    acc_zero_q <= sum_zero;
                end
                if (out_valid_q && out_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_next;
    logic [15:0] out_count_q;

    assign cnt_next    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign out_count_o = out_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            out_count_q <= '0;
        end else if (accept) begin
            if (in_last_i) begin
                out_count_q <= cnt_next;
                cnt_q       <= '0;
            end else begin
                cnt_q <= cnt_next;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dim1_mod_accumulator.sv
// Bench for dim1_mod_accumulator: table vectors, hand-written handshake/reset
// sequences, and random frames checked against a plain modulo-257 model.
module tb_dim1_mod_accumulator;
    localparam int W   = 8;
    localparam int MOD = (1 << W) + 1;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] in_data_i = '0;
    logic         in_zero_i = 1'b0;
    logic         in_last_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] out_data_o;
    logic         out_zero_o;
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
    logic [15:0]  out_count_o;
`endif

    dim1_mod_accumulator #(.width(W), .speed(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data_i),
        .in_zero_i  (in_zero_i),
        .in_last_i  (in_last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_zero_o (out_zero_o)
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
        ,
        .out_count_o(out_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    bit rnd_ready_en = 1'b0;
    logic [W:0] exp_q[$];
    logic [15:0] exp_cnt_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one beat of true value v (0..256) and returns just after it is accepted.
    task automatic send_beat(input int v, input bit last);
        int  budget;
        bit  rdy;
        budget = 0;
        forever begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_zero_i  = (v == 0);
            in_data_i  = (v == 0) ? W'($urandom) : W'(v - 1);
            in_last_i  = last;
            #1 rdy = in_ready_o;
            @(posedge clk_i);
            if (rdy) break;
            budget++;
            if (budget > 50) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        #1 in_valid_i = 1'b0;
        in_last_i = 1'b0;
    endtask

    // Scoreboard: compares every output handshake with the oldest expected frame.
    initial begin
        logic [W:0]  e;
        logic [15:0] ec;
        forever begin
            @(negedge clk_i);
            #3;
            if (mon_en && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cnt_q.pop_front();
                    check("rnd_zero", 32'(out_zero_o), 32'(e[W]));
                    check("rnd_data", 32'(out_data_o), 32'(e[W-1:0]));
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
                    check("rnd_count", 32'(out_count_o), 32'(ec));
`endif
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (rnd_ready_en) out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        int           n;
        int           v[4];
        logic [W-1:0] data;
        logic         zero;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, '{5, 0, 0, 0},       8'd4,   1'b0};
        tbl[1] = '{2, '{200, 100, 0, 0},   8'd42,  1'b0};
        tbl[2] = '{2, '{128, 129, 0, 0},   8'd0,   1'b1};
        tbl[3] = '{3, '{0, 7, 0, 0},       8'd6,   1'b0};
        tbl[4] = '{2, '{0, 0, 0, 0},       8'd0,   1'b1};
        tbl[5] = '{1, '{256, 0, 0, 0},     8'd255, 1'b0};
        tbl[6] = '{2, '{256, 256, 0, 0},   8'd254, 1'b0};
        tbl[7] = '{2, '{1, 256, 0, 0},     8'd0,   1'b1};
        tbl[8] = '{1, '{0, 0, 0, 0},       8'd0,   1'b1};
        tbl[9] = '{4, '{100, 100, 100, 1}, 8'd43,  1'b0};

        // Reset state, both during and after reset.
        #2;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready_o), 32'd1);
        check("post_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("post_rst_out_data", 32'(out_data_o), 32'd0);
        check("post_rst_out_zero", 32'(out_zero_o), 32'd0);
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
        check("post_rst_out_count", 32'(out_count_o), 32'd0);
`endif

        // Table vectors with the output always ready.
        out_ready_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int b = 0; b < tbl[t].n; b++) send_beat(tbl[t].v[b], b == tbl[t].n - 1);
            @(negedge clk_i);
            #3;
            check($sformatf("tbl%0d_valid", t), 32'(out_valid_o), 32'd1);
            check($sformatf("tbl%0d_zero", t), 32'(out_zero_o), 32'(tbl[t].zero));
            check($sformatf("tbl%0d_data", t), 32'(out_data_o), 32'(tbl[t].data));
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
            check($sformatf("tbl%0d_count", t), 32'(out_count_o), 32'(tbl[t].n));
`endif
        end

        // Backpressure: result held while out_ready is low, then drain and reload together.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        send_beat(10, 1'b0);
        send_beat(20, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #3;
            check("bp_valid", 32'(out_valid_o), 32'd1);
            check("bp_in_ready", 32'(in_ready_o), 32'd0);
            check("bp_data", 32'(out_data_o), 32'd29);
            check("bp_zero", 32'(out_zero_o), 32'd0);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_zero_i   = 1'b0;
        in_data_i   = 8'd8;
        in_last_i   = 1'b1;
        #1 check("bp_in_ready_drain", 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        in_last_i = 1'b0;
        @(negedge clk_i);
        #3;
        check("bp_reload_valid", 32'(out_valid_o), 32'd1);
        check("bp_reload_data", 32'(out_data_o), 32'd8);
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
        check("bp_reload_count", 32'(out_count_o), 32'd1);
`endif
        @(negedge clk_i);
        #3;
        check("bp_drained_valid", 32'(out_valid_o), 32'd0);

        // Asynchronous reset mid-frame discards the partial sum.
        send_beat(50, 1'b0);
        send_beat(60, 1'b0);
        #6 rst_i = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        send_beat(3, 1'b1);
        @(negedge clk_i);
        #3;
        check("mid_rst_valid", 32'(out_valid_o), 32'd1);
        check("mid_rst_data", 32'(out_data_o), 32'd2);
        check("mid_rst_zero", 32'(out_zero_o), 32'd0);
`ifdef DIM1_MOD_ACC_BEAT_COUNT_EN
        check("mid_rst_count", 32'(out_count_o), 32'd1);
`endif
        @(negedge clk_i);

        // Random frames against the modulo-257 model.
        mon_en       = 1'b1;
        rnd_ready_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int len;
            int s;
            int v;
            int r;
            len = $urandom_range(1, 5);
            s   = 0;
            for (int b = 0; b < len; b++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      v = 0;
                else if (r == 1) v = MOD - 1;
                else if (r == 2) v = (MOD - s) % MOD;
                else             v = $urandom_range(1, MOD - 1);
                repeat ($urandom_range(0, 1)) @(posedge clk_i);
                send_beat(v, b == len - 1);
                s = (s + v) % MOD;
            end
            exp_q.push_back({(s == 0), (s == 0) ? W'(0) : W'(s - 1)});
            exp_cnt_q.push_back(16'(len));
        end
        rnd_ready_en = 1'b0;
        @(negedge clk_i);
        out_ready_i = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk_i);
        repeat (2) @(negedge clk_i);
        check("rnd_all_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
